uart_frame_tx: RTL and testbench

Parametrised successor to the 18-channel spike UART transmitter. While enabled, it periodically samples N_CH channel inputs and sends them as a byte-framed 8N1 UART packet. Each packet is a header byte, the packed channel bytes, and an optional checksum byte. It sits between the neuromorphic channel logic and the PC link, and adds overrun detection and frame-done signalling.

---
 rtl/uart_frame_if.sv | 35 +++
 rtl/uart_frame_tx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 566 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_if.sv
// Channel-sampling UART frame transmitter bus.
// Groups the enable/sample inputs and the serial/status outputs.
interface uart_frame_if #(
    parameter int N_CH = 18
);
    logic            uart_start;
    logic [N_CH-1:0] ch_in;
    logic            uart_txd;
    logic            tx_busy;
    logic            sample_strobe;
    logic            frame_done;
    logic            overrun;

    // Channel logic / host side
    modport master (
        output uart_start,
        output ch_in,
        input  uart_txd,
        input  tx_busy,
        input  sample_strobe,
        input  frame_done,
        input  overrun
    );

    // Transmitter side
    modport slave (
        input  uart_start,
        input  ch_in,
        output uart_txd,
        output tx_busy,
        output sample_strobe,
        output frame_done,
        output overrun
    );
endinterface

// File: rtl/uart_frame_tx.sv
// Periodic N_CH-channel sampler sending HEADER + packed bytes as 8N1.
// Optional checksum byte (XOR of all prior bytes) via UART_CHECKSUM_EN.
module uart_frame_tx #(
    parameter int         N_CH         = 18,
    parameter int         CLKS_PER_BIT = 576,
    parameter int         PERIOD_BITS  = 64,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input logic         sys_clk,
    input logic         sys_reset,
    uart_frame_if.slave bus
);

    localparam int NB = (N_CH + 7) / 8;
`ifdef UART_CHECKSUM_EN
    localparam int N_BYTES = NB + 2;
`else
    localparam int N_BYTES = NB + 1;
`endif
    localparam int PERIOD_CLKS = CLKS_PER_BIT * PERIOD_BITS;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(NB + 2);
    localparam int PW = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CLKS - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(N_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     clk_q, clk_d;
    logic [2:0]        bit_q, bit_d;
    logic [BW-1:0]     byte_q, byte_d;
    logic [PW-1:0]     per_q, per_d;
    logic [NB*8-1:0]   shadow_q, shadow_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;

    logic              tick;
    logic              bit_end;
    logic [NB*8-1:0]   ch_pad;
    logic [7:0]        cur_byte;
`ifdef UART_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign tick = bus.uart_start && (per_q == PER_LAST);

    // Zero-pad the channel vector up to a whole number of bytes
    always_comb begin
        ch_pad = '0;
        ch_pad[N_CH-1:0] = bus.ch_in;
    end

    // Select the byte currently on the wire from the byte index
    always_comb begin
        cur_byte = HEADER;
`ifdef UART_CHECKSUM_EN
        csum = HEADER;
`endif
        for (int k = 0; k < NB; k++) begin
`ifdef UART_CHECKSUM_EN
            csum = csum ^ shadow_q[8*k +: 8];
`endif
            if (int'(byte_q) == k + 1) begin
                cur_byte = shadow_q[8*k +: 8];
            end
        end
`ifdef UART_CHECKSUM_EN
        if (int'(byte_q) == NB + 1) begin
            cur_byte = csum;
        end
`endif
    end

    // Sampling period counter, held at zero while disabled
    always_comb begin
        per_d = per_q + 1'b1;
        if (!bus.uart_start || per_q == PER_LAST) begin
            per_d = '0;
        end
    end

    // Sticky overrun: tick while a frame is still on the wire
    always_comb begin
        ovr_d = ovr_q;
        if (!bus.uart_start) begin
            ovr_d = 1'b0;
        end else if (tick && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end
    end

    // Frame FSM next-state, bit timing and registered serial data
    always_comb begin
        state_d  = state_q;
        clk_d    = clk_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shadow_d = shadow_q;
        txd_d    = txd_q;
        done_d   = 1'b0;
        bit_end  = (clk_q == CLK_LAST);
        unique case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (tick) begin
                    state_d  = S_START;
                    shadow_d = ch_pad;
                    clk_d    = '0;
                    bit_d    = '0;
                    byte_d   = '0;
                    txd_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    clk_d   = '0;
                    bit_d   = '0;
                    txd_d   = cur_byte[0];
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    clk_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    clk_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        txd_d   = 1'b1;
                    end else begin
                        state_d = S_START;
                        byte_d  = byte_q + 1'b1;
                        txd_d   = 1'b0;
                    end
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q  <= S_IDLE;
            clk_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            per_q    <= '0;
            shadow_q <= '0;
            txd_q    <= 1'b1;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            clk_q    <= clk_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            per_q    <= per_d;
            shadow_q <= shadow_d;
            txd_q    <= txd_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.uart_txd      = txd_q;
    assign bus.tx_busy       = (state_q != S_IDLE);
    assign bus.frame_done    = done_q;
    assign bus.overrun       = ovr_q;
    assign bus.sample_strobe = tick && (state_q == S_IDLE) && !sys_reset;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: DUT A (64-bit period) and DUT B (32-bit period).
// Outputs captured per cycle and compared with a frame-schedule model.
`timescale 1ns/1ps
module tb_uart_frame_tx;

    localparam int N_CH = 18;
    localparam int CPB  = 4;
    localparam int PA   = 256;
    localparam int PB   = 128;
    localparam int NB   = 3;
`ifdef UART_CHECKSUM_EN
    localparam int NBYTES = NB + 2;
`else
    localparam int NBYTES = NB + 1;
`endif
    localparam int FL   = NBYTES * 10 * CPB;
    localparam int MAXC = 1024;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s = 1'b0;
    logic [17:0] ch_s = '0;

    int nvec = 0;
    int nerr = 0;

    logic        c_txd  [0:1][0:MAXC-1];
    logic        c_busy [0:1][0:MAXC-1];
    logic        c_stb  [0:1][0:MAXC-1];
    logic        c_done [0:1][0:MAXC-1];
    logic        c_ovr  [0:1][0:MAXC-1];
    logic        e_txd  [0:1][0:MAXC-1];
    logic        e_busy [0:1][0:MAXC-1];
    logic        e_stb  [0:1][0:MAXC-1];
    logic        e_done [0:1][0:MAXC-1];
    logic        e_ovr  [0:1][0:MAXC-1];
    logic        st_at  [0:MAXC-1];
    logic [17:0] ch_at  [0:MAXC-1];

    logic [7:0] exp_basic [0:4] = '{8'hA5, 8'hC3, 8'hA5, 8'h02, 8'hC1};
    logic [7:0] exp_chg   [0:4] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'hA4};

    always #5 clk = ~clk;

    uart_frame_if #(.N_CH(N_CH)) ifa ();
    uart_frame_if #(.N_CH(N_CH)) ifb ();

    assign ifa.uart_start = start_s;
    assign ifa.ch_in      = ch_s;
    assign ifb.uart_start = start_s;
    assign ifb.ch_in      = ch_s;

    uart_frame_tx #(
        .N_CH(N_CH), .CLKS_PER_BIT(CPB),
        .PERIOD_BITS(64), .HEADER(8'hA5)
    ) dut_a (
        .sys_clk(clk), .sys_reset(rst), .bus(ifa.slave)
    );

    uart_frame_tx #(
        .N_CH(N_CH), .CLKS_PER_BIT(CPB),
        .PERIOD_BITS(32), .HEADER(8'hA5)
    ) dut_b (
        .sys_clk(clk), .sys_reset(rst), .bus(ifb.slave)
    );

    // Reference frame content straight from the byte rules
    function automatic bq_t build(input logic [17:0] ch);
        bq_t q;
        logic [23:0] p;
        logic [7:0] x;
        p = {6'b0, ch};
        x = 8'hA5;
        q.push_back(8'hA5);
        for (int k = 0; k < NB; k++) begin
            q.push_back(p[8*k +: 8]);
            x = x ^ p[8*k +: 8];
        end
`ifdef UART_CHECKSUM_EN
        q.push_back(x);
`endif
        return q;
    endfunction

    // Level of bit-time k of a frame: start, 8 data LSB first, stop
    function automatic logic frame_bit(input bq_t fb, input int k);
        int by;
        int pos;
        by  = k / 10;
        pos = k % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return fb[by][pos-1];
    endfunction

    // Behavioural schedule: ticks every per cycles of enable, frames
    // start the cycle after an accepted tick and last FL cycles
    task automatic model(input int d, input int per, input int n);
        int run;
        int s;
        logic ovr;
        bq_t fb;
        run = 0;
        s = -100000;
        ovr = 1'b0;
        fb = build(18'h0);
        for (int c = 1; c <= n; c++) begin
            logic tk;
            logic bz;
            tk = st_at[c] && (run % per == per - 1);
            bz = (c >= s) && (c < s + FL);
            e_busy[d][c] = bz;
            e_done[d][c] = (c == s + FL);
            e_ovr[d][c]  = ovr;
            e_stb[d][c]  = tk && !bz;
            e_txd[d][c]  = bz ? frame_bit(fb, (c - s) / CPB) : 1'b1;
            if (!st_at[c]) ovr = 1'b0;
            else if (tk && bz) ovr = 1'b1;
            if (tk && !bz) begin
                s = c + 1;
                fb = build(ch_at[c]);
            end
            run = st_at[c] ? run + 1 : 0;
        end
    endtask

    function automatic logic capv(input int sel, input int d, input int c);
        case (sel)
            0: return c_txd[d][c];
            1: return c_busy[d][c];
            2: return c_stb[d][c];
            3: return c_done[d][c];
            default: return c_ovr[d][c];
        endcase
    endfunction

    function automatic logic expv(input int sel, input int d, input int c);
        case (sel)
            0: return e_txd[d][c];
            1: return e_busy[d][c];
            2: return e_stb[d][c];
            3: return e_done[d][c];
            default: return e_ovr[d][c];
        endcase
    endfunction

    function automatic int ndiff(input int sel, input int d, input int n,
                                 output int first);
        int k;
        k = 0;
        first = -1;
        for (int c = 1; c <= n; c++) begin
            if (capv(sel, d, c) !== expv(sel, d, c)) begin
                if (first < 0) first = c;
                k++;
            end
        end
        return k;
    endfunction

    function automatic int first_val(input int sel, input int d,
                                     input int from, input int n,
                                     input logic v);
        for (int c = from; c <= n; c++) begin
            if (capv(sel, d, c) === v) return c;
        end
        return -1;
    endfunction

    function automatic int count_hi(input int sel, input int d,
                                    input int from, input int to);
        int k;
        k = 0;
        for (int c = from; c <= to; c++) begin
            if (capv(sel, d, c) === 1'b1) k++;
        end
        return k;
    endfunction

    // Mid-bit UART receiver over the captured line
    function automatic bq_t decode(input int d, input int s, input int nb);
        bq_t q;
        logic [7:0] b;
        for (int k = 0; k < nb; k++) begin
            for (int i = 0; i < 8; i++) begin
                b[i] = c_txd[d][s + (k*10 + 1 + i)*CPB + CPB/2];
            end
            q.push_back(b);
        end
        return q;
    endfunction

    task automatic do_reset();
        start_s = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Cycle 1 is the first cycle with uart_start high; sample at negedge
    task automatic capture(input int n, input int off_cyc, input int chg_cyc,
                           input logic [17:0] ch0, input logic [17:0] ch1,
                           input int rst_on, input int rst_off);
        start_s = 1'b1;
        ch_s = ch0;
        for (int c = 1; c <= n; c++) begin
            if (c == off_cyc) start_s = 1'b0;
            if (c == chg_cyc) ch_s = ch1;
            if (c == rst_on) rst = 1'b1;
            if (c == rst_off) rst = 1'b0;
            st_at[c] = start_s;
            ch_at[c] = ch_s;
            @(negedge clk);
            c_txd[0][c]  = ifa.uart_txd;
            c_busy[0][c] = ifa.tx_busy;
            c_stb[0][c]  = ifa.sample_strobe;
            c_done[0][c] = ifa.frame_done;
            c_ovr[0][c]  = ifa.overrun;
            c_txd[1][c]  = ifb.uart_txd;
            c_busy[1][c] = ifb.tx_busy;
            c_stb[1][c]  = ifb.sample_strobe;
            c_done[1][c] = ifb.frame_done;
            c_ovr[1][c]  = ifb.overrun;
            @(posedge clk);
            #1;
        end
        start_s = 1'b0;
    endtask

    task automatic test_reset();
        start_s = 1'b1;
        ch_s = 18'h3FFFF;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        nvec++;
        if (ifa.uart_txd !== 1'b1) begin
            nerr++;
            $display("FAIL reset_txd: got %b want 1", ifa.uart_txd);
        end
        nvec++;
        if (ifa.tx_busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_busy: got %b want 0", ifa.tx_busy);
        end
        nvec++;
        if (ifa.sample_strobe !== 1'b0) begin
            nerr++;
            $display("FAIL reset_strobe: got %b want 0", ifa.sample_strobe);
        end
        nvec++;
        if (ifa.frame_done !== 1'b0) begin
            nerr++;
            $display("FAIL reset_done: got %b want 0", ifa.frame_done);
        end
        nvec++;
        if (ifb.overrun !== 1'b0) begin
            nerr++;
            $display("FAIL reset_overrun: got %b want 0", ifb.overrun);
        end
        @(posedge clk);
        #1;
        start_s = 1'b0;
    endtask

    task automatic test_idle_hold();
        int bad_txd;
        int n_busy;
        int n_stb;
        int n_done;
        do_reset();
        bad_txd = 0;
        n_busy = 0;
        n_stb = 0;
        n_done = 0;
        for (int c = 0; c < 1000; c++) begin
            if (c % 100 == 0) ch_s = 18'($urandom);
            @(negedge clk);
            if (ifa.uart_txd !== 1'b1) bad_txd++;
            if (ifa.tx_busy !== 1'b0) n_busy++;
            if (ifa.sample_strobe !== 1'b0) n_stb++;
            if (ifa.frame_done !== 1'b0) n_done++;
        end
        nvec++;
        if (bad_txd !== 0) begin
            nerr++;
            $display("FAIL idle_txd: got %0d low cycles want 0", bad_txd);
        end
        nvec++;
        if (n_busy !== 0) begin
            nerr++;
            $display("FAIL idle_busy: got %0d busy cycles want 0", n_busy);
        end
        nvec++;
        if (n_stb !== 0) begin
            nerr++;
            $display("FAIL idle_strobe: got %0d strobes want 0", n_stb);
        end
        nvec++;
        if (n_done !== 0) begin
            nerr++;
            $display("FAIL idle_done: got %0d pulses want 0", n_done);
        end
    endtask

    task automatic test_basic_frame();
        bq_t got;
        int v;
        int f;
        int nd;
        string nm [0:4] = '{"txd", "busy", "strobe", "done", "overrun"};
        do_reset();
        capture(800, 0, 0, 18'h2A5C3, 18'h0, 0, 0);
        model(0, PA, 800);
        v = first_val(2, 0, 1, 800, 1'b1);
        nvec++;
        if (v !== 256) begin
            nerr++;
            $display("FAIL basic_strobe_cycle: got %0d want 256", v);
        end
        v = first_val(0, 0, 1, 800, 1'b0);
        nvec++;
        if (v !== 257) begin
            nerr++;
            $display("FAIL basic_start_cycle: got %0d want 257", v);
        end
        got = decode(0, 257, NBYTES);
        for (int k = 0; k < NBYTES; k++) begin
            nvec++;
            if (got[k] !== exp_basic[k]) begin
                nerr++;
                $display("FAIL basic_byte%0d: got %h want %h",
                         k, got[k], exp_basic[k]);
            end
        end
        v = first_val(3, 0, 1, 800, 1'b1);
        nvec++;
        if (v !== 257 + FL) begin
            nerr++;
            $display("FAIL basic_done_cycle: got %0d want %0d", v, 257 + FL);
        end
        v = first_val(0, 0, 257 + FL, 800, 1'b0);
        nvec++;
        if (v !== 513) begin
            nerr++;
            $display("FAIL basic_next_start: got %0d want 513", v);
        end
        for (int s = 0; s < 5; s++) begin
            nd = ndiff(s, 0, 800, f);
            nvec++;
            if (nd !== 0) begin
                nerr++;
                $display("FAIL basic_wave_%s: got %0d bad cycles (first %0d) want 0",
                         nm[s], nd, f);
            end
        end
    endtask

    task automatic test_input_change();
        bq_t g1;
        bq_t g2;
        int f;
        int nd;
        do_reset();
        capture(800, 0, 302, 18'h2A5C3, 18'h00001, 0, 0);
        model(0, PA, 800);
        g1 = decode(0, 257, NBYTES);
        g2 = decode(0, 513, NBYTES);
        for (int k = 0; k < NBYTES; k++) begin
            nvec++;
            if (g1[k] !== exp_basic[k]) begin
                nerr++;
                $display("FAIL chg_frame1_byte%0d: got %h want %h",
                         k, g1[k], exp_basic[k]);
            end
            nvec++;
            if (g2[k] !== exp_chg[k]) begin
                nerr++;
                $display("FAIL chg_frame2_byte%0d: got %h want %h",
                         k, g2[k], exp_chg[k]);
            end
        end
        nd = ndiff(0, 0, 800, f);
        nvec++;
        if (nd !== 0) begin
            nerr++;
            $display("FAIL chg_wave_txd: got %0d bad cycles (first %0d) want 0",
                     nd, f);
        end
    endtask

    task automatic test_overrun();
        logic [17:0] ch;
        bq_t got;
        bq_t ref_q;
        int f;
        int nd;
        int ns;
        ch = 18'($urandom);
        do_reset();
        capture(700, 400, 0, ch, ch, 0, 0);
        model(1, PB, 700);
        nvec++;
        if (c_ovr[1][256] !== 1'b0) begin
            nerr++;
            $display("FAIL ovr_before_tick: got %b want 0", c_ovr[1][256]);
        end
        nvec++;
        if (c_ovr[1][257] !== 1'b1) begin
            nerr++;
            $display("FAIL ovr_after_tick: got %b want 1", c_ovr[1][257]);
        end
        nvec++;
        if (c_ovr[1][399] !== 1'b1) begin
            nerr++;
            $display("FAIL ovr_sticky: got %b want 1", c_ovr[1][399]);
        end
        nvec++;
        if (c_ovr[1][401] !== 1'b0) begin
            nerr++;
            $display("FAIL ovr_clear: got %b want 0", c_ovr[1][401]);
        end
        ns = count_hi(2, 1, 1, 700);
        nvec++;
        if (ns !== 2) begin
            nerr++;
            $display("FAIL ovr_strobes: got %0d want 2", ns);
        end
        nvec++;
        if (c_done[1][385 + FL] !== 1'b1) begin
            nerr++;
            $display("FAIL ovr_inflight_done: got %b want 1",
                     c_done[1][385 + FL]);
        end
        got = decode(1, 385, NBYTES);
        ref_q = build(ch);
        nd = 0;
        for (int k = 0; k < NBYTES; k++) begin
            if (got[k] !== ref_q[k]) nd++;
        end
        nvec++;
        if (nd !== 0) begin
            nerr++;
            $display("FAIL ovr_inflight_bytes: got %0d bad bytes want 0", nd);
        end
        for (int s = 0; s < 5; s++) begin
            nd = ndiff(s, 1, 700, f);
            nvec++;
            if (nd !== 0) begin
                nerr++;
                $display("FAIL ovr_wave_sig%0d: got %0d bad cycles (first %0d) want 0",
                         s, nd, f);
            end
        end
    endtask

    task automatic test_reset_mid_bit();
        bq_t got;
        int v;
        int n;
        n = 569 + FL + 5;
        do_reset();
        capture(n, 0, 0, 18'h2A5C3, 18'h2A5C3, 310, 313);
        nvec++;
        if (c_txd[0][310] !== 1'b0) begin
            nerr++;
            $display("FAIL rmb_bit_low: got %b want 0", c_txd[0][310]);
        end
        nvec++;
        if (c_ovr[1][310] !== 1'b1) begin
            nerr++;
            $display("FAIL rmb_ovr_pre: got %b want 1", c_ovr[1][310]);
        end
        nvec++;
        if (c_txd[0][311] !== 1'b1) begin
            nerr++;
            $display("FAIL rmb_txd: got %b want 1", c_txd[0][311]);
        end
        nvec++;
        if (c_busy[0][311] !== 1'b0) begin
            nerr++;
            $display("FAIL rmb_busy: got %b want 0", c_busy[0][311]);
        end
        nvec++;
        if (c_ovr[1][311] !== 1'b0) begin
            nerr++;
            $display("FAIL rmb_ovr: got %b want 0", c_ovr[1][311]);
        end
        v = count_hi(3, 0, 297, 568);
        nvec++;
        if (v !== 0) begin
            nerr++;
            $display("FAIL rmb_no_done: got %0d pulses want 0", v);
        end
        v = first_val(2, 0, 311, n, 1'b1);
        nvec++;
        if (v !== 568) begin
            nerr++;
            $display("FAIL rmb_resume_strobe: got %0d want 568", v);
        end
        got = decode(0, 569, NBYTES);
        v = 0;
        for (int k = 0; k < NBYTES; k++) begin
            if (got[k] !== exp_basic[k]) v++;
        end
        nvec++;
        if (v !== 0) begin
            nerr++;
            $display("FAIL rmb_resume_bytes: got %0d bad bytes want 0", v);
        end
        nvec++;
        if (c_done[0][569 + FL] !== 1'b1) begin
            nerr++;
            $display("FAIL rmb_resume_done: got %b want 1", c_done[0][569 + FL]);
        end
    endtask

    task automatic test_random_frames();
        logic [17:0] ch;
        bq_t got;
        bq_t ref_q;
        int f;
        int nd;
        for (int it = 0; it < 4; it++) begin
            ch = 18'($urandom);
            do_reset();
            capture(450, 0, 0, ch, ch, 0, 0);
            model(0, PA, 450);
            nd = ndiff(0, 0, 450, f);
            nvec++;
            if (nd !== 0) begin
                nerr++;
                $display("FAIL rnd%0d_wave ch=%h: got %0d bad cycles (first %0d) want 0",
                         it, ch, nd, f);
            end
            got = decode(0, 257, NBYTES);
            ref_q = build(ch);
            nd = 0;
            for (int k = 0; k < NBYTES; k++) begin
                if (got[k] !== ref_q[k]) nd++;
            end
            nvec++;
            if (nd !== 0) begin
                nerr++;
                $display("FAIL rnd%0d_bytes ch=%h: got %0d bad bytes want 0",
                         it, ch, nd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_basic_frame();
        test_input_change();
        test_overrun();
        test_reset_mid_bit();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
